// File: rtl/serial_tx_sequencer_pkg.sv
// Shared encodings for the serial transmit sequencer and its downstream shift register.
// The optional frame-length checker is enabled by defining SERIAL_TX_SEQ_CHECK_EN.
package serial_tx_sequencer_pkg;

    typedef enum logic [1:0] {
        CTRL_NOP     = 2'b00,
        CTRL_SHIFT_L = 2'b01,
        CTRL_SHIFT_R = 2'b10,
        CTRL_LOAD    = 2'b11
    } sr_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

    // Counter width for a count range, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned value);
        return (value > 32'd1) ? $clog2(value) : 32'd1;
    endfunction

endpackage

// File: rtl/serial_tx_sequencer_if.sv
// Handshake and shift-register control bundle between a client, the sequencer and the
// shift register. The slave modport is the sequencer's view.
interface serial_tx_sequencer_if
    import serial_tx_sequencer_pkg::*;
#(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   din;
    logic           ready;
    logic           busy;
    logic           done;
    logic           err;
    logic           sr_trigger;
    sr_ctrl_e       sr_ctrl;
    logic [N-1:0]   sr_d;
    logic           sr_last_tick;

    modport master (
        output start, din, sr_last_tick,
        input  ready, busy, done, err, sr_trigger, sr_ctrl, sr_d
    );

    modport slave (
        input  start, din, sr_last_tick,
        output ready, busy, done, err, sr_trigger, sr_ctrl, sr_d
    );
endinterface

// File: rtl/serial_tx_sequencer_bit_period_counter.sv
// Modulo-DIV bit-period counter with synchronous clear and terminal-count flag.
module bit_period_counter
    import serial_tx_sequencer_pkg::*;
#(
    parameter  int DIV = 16,
    localparam int CW  = cnt_width(DIV)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tc
);
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise wrap at DIV-1.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q == CW'(DIV - 1)) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == CW'(DIV - 1));
endmodule

// File: rtl/serial_tx_sequencer.sv
// Drives a start/done parallel-to-serial shift register: one LOAD, then SHIFT_L per bit period.
// Define SERIAL_TX_SEQ_CHECK_EN to add the frame-length checker driving err.
module serial_tx_sequencer
    import serial_tx_sequencer_pkg::*;
#(
    parameter int N   = 8,
    parameter int DIV = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_tx_sequencer_if.slave bus
);
    localparam int CW = cnt_width(DIV);

    seq_state_e     state_q, state_d;
    logic [N-1:0]   hold_q, hold_d;
    logic           trig_q, trig_d;
    sr_ctrl_e       ctrl_q, ctrl_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic           end_q, end_d;
    logic           cnt_clr;
    logic [CW-1:0]  bp_count;
    logic           bp_tc;
    logic           bp_pre;
    logic           frame_end;
    logic           frame_err;

    bit_period_counter #(.DIV(DIV)) u_bit_period_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .count (bp_count),
        .tc    (bp_tc)
    );

    // Outputs are registered, so the period-end decision is taken one cycle early.
    // last_tick only moves on a trigger, so it is already settled at DIV-2.
    assign bp_pre = (bp_count == CW'(DIV - 2));

`ifdef SERIAL_TX_SEQ_CHECK_EN
    localparam int SW = cnt_width(N);
    logic [SW-1:0] shcnt_q, shcnt_d;
    logic          at_last;
    assign at_last   = (shcnt_q == SW'(N - 1));
    assign frame_end = at_last | bus.sr_last_tick;
    assign frame_err = at_last ^ bus.sr_last_tick;
`else
    assign frame_end = bus.sr_last_tick;
    assign frame_err = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        trig_d  = 1'b0;
        ctrl_d  = CTRL_NOP;
        done_d  = 1'b0;
        ready_d = 1'b0;
        end_d   = end_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
`ifdef SERIAL_TX_SEQ_CHECK_EN
        shcnt_d = shcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start && ready_q) begin
                    state_d = ST_LOAD;
                    hold_d  = bus.din;
                    trig_d  = 1'b1;
                    ctrl_d  = CTRL_LOAD;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_clr = 1'b1;
                end_d   = 1'b0;
                state_d = ST_SHIFT;
`ifdef SERIAL_TX_SEQ_CHECK_EN
                shcnt_d = '0;
`endif
            end
            ST_SHIFT: begin
                if (bp_pre) begin
                    if (frame_end) begin
                        end_d = 1'b1;
                        err_d = err_q | frame_err;
                    end else begin
                        trig_d = 1'b1;
                        ctrl_d = CTRL_SHIFT_L;
`ifdef SERIAL_TX_SEQ_CHECK_EN
                        shcnt_d = shcnt_q + SW'(1);
`endif
                    end
                end else if (bp_tc && end_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            trig_q  <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            end_q   <= 1'b0;
`ifdef SERIAL_TX_SEQ_CHECK_EN
            shcnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            end_q   <= end_d;
`ifdef SERIAL_TX_SEQ_CHECK_EN
            shcnt_q <= shcnt_d;
`endif
        end
    end

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.sr_trigger = trig_q;
    assign bus.sr_ctrl    = ctrl_q;
    assign bus.sr_d       = hold_q;
endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Bench for serial_tx_sequencer: two instances (DIV=4 and DIV=2), each paired with a
// behavioural shift register; expectations come from the frame timeline formulas.
module tb_serial_tx_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       sel;
    logic       force_lt0;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_t = 0;

    serial_tx_sequencer_if #(.N(8)) bus0 ();
    serial_tx_sequencer_if #(.N(8)) bus1 ();

    serial_tx_sequencer #(.N(8), .DIV(4)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    serial_tx_sequencer #(.N(8), .DIV(2)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Behavioural shift registers; trigger counter wraps after N triggers.
    logic [7:0] sr0_reg, sr1_reg;
    int         sr0_cnt, sr1_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sr0_reg <= 8'h00;
            sr0_cnt <= 0;
        end else if (bus0.sr_trigger) begin
            sr0_cnt <= (sr0_cnt >= 8) ? 1 : sr0_cnt + 1;
            case (bus0.sr_ctrl)
                2'b11:   sr0_reg <= bus0.sr_d;
                2'b01:   sr0_reg <= {sr0_reg[6:0], 1'b0};
                2'b10:   sr0_reg <= {1'b0, sr0_reg[7:1]};
                default: sr0_reg <= sr0_reg;
            endcase
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sr1_reg <= 8'h00;
            sr1_cnt <= 0;
        end else if (bus1.sr_trigger) begin
            sr1_cnt <= (sr1_cnt >= 8) ? 1 : sr1_cnt + 1;
            case (bus1.sr_ctrl)
                2'b11:   sr1_reg <= bus1.sr_d;
                2'b01:   sr1_reg <= {sr1_reg[6:0], 1'b0};
                2'b10:   sr1_reg <= {1'b0, sr1_reg[7:1]};
                default: sr1_reg <= sr1_reg;
            endcase
        end
    end

    assign bus0.start        = start & ~sel;
    assign bus0.din          = din;
    assign bus0.sr_last_tick = force_lt0 ? 1'b0 : (sr0_cnt == 8);
    assign bus1.start        = start & sel;
    assign bus1.din          = din;
    assign bus1.sr_last_tick = (sr1_cnt == 8);

    logic       o_ready, o_busy, o_done, o_err, o_trig, o_q;
    logic [1:0] o_ctrl;
    logic [7:0] o_srd;
    assign o_ready = sel ? bus1.ready      : bus0.ready;
    assign o_busy  = sel ? bus1.busy       : bus0.busy;
    assign o_done  = sel ? bus1.done       : bus0.done;
    assign o_err   = sel ? bus1.err        : bus0.err;
    assign o_trig  = sel ? bus1.sr_trigger : bus0.sr_trigger;
    assign o_ctrl  = sel ? bus1.sr_ctrl    : bus0.sr_ctrl;
    assign o_srd   = sel ? bus1.sr_d       : bus0.sr_d;
    assign o_q     = sel ? sr1_reg[7]      : sr0_reg[7];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk1("rst_ready", o_ready, 1'b1);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_done", o_done, 1'b0);
        chk1("rst_err", o_err, 1'b0);
        chk1("rst_trig", o_trig, 1'b0);
        chk8("rst_ctrl", 8'(o_ctrl), 8'h00);
        chk8("rst_sr_d", o_srd, 8'h00);
    endtask

    // One frame accepted in the current cycle t; checks cycles t+1 .. t+2+N*DIV and
    // returns in cycle t+3+N*DIV. hold keeps start high with nxt on din throughout.
    task automatic frame(input logic [7:0] w, input bit reject, input bit hold,
                         input logic [7:0] nxt, input bit exp_err);
        int  div, nd, loads, shifts, bad;
        bit  exp_trig;
        div = sel ? 2 : 4;
        nd = 8 * div;
        loads = 0;
        shifts = 0;
        bad = 0;
        chk1("ready_at_accept", o_ready, 1'b1);
        start = 1'b1;
        din = w;
        last_t = cyc;
        for (int c = 1; c <= nd + 2; c++) begin
            tick();
            start = hold;
            din = nxt;
            if (reject && c == 5) begin
                start = 1'b1;
                din = 8'hFF;
            end
            exp_trig = ((c - 1) % div == 0) && (c - 1 < nd);
            if (o_trig) begin
                if (o_ctrl == 2'b11) loads++;
                else if (o_ctrl == 2'b01) shifts++;
                else bad++;
            end
            chk1("trigger", o_trig, exp_trig);
            chk1("done", o_done, c == nd + 2);
            chk1("busy", o_busy, 1'b1);
            chk1("ready_low", o_ready, 1'b0);
            chk8("sr_d", o_srd, w);
            chk1("err", o_err, exp_err && (c >= nd + 1));
            if (c >= 2 && c <= nd + 1) chk1("q_bit", o_q, w[7 - (c - 2) / div]);
        end
        chk8("load_count", 8'(loads), 8'd1);
        chk8("shift_l_count", 8'(shifts), 8'd7);
        chk8("bad_ctrl_count", 8'(bad), 8'd0);
        tick();
    endtask

    initial begin
        int t1;
        logic [7:0] w;
        reset = 1'b1;
        start = 1'b0;
        din = 8'h00;
        sel = 1'b0;
        force_lt0 = 1'b0;
        tick();
        tick();
        chk_reset_vals();
        reset = 1'b0;
        tick();
        chk_reset_vals();

        // Basic frame with a rejected start in flight.
        frame(8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();

        // Back-to-back with start held high.
        frame(8'h3C, 1'b0, 1'b1, 8'hC3, 1'b0);
        t1 = last_t;
        frame(8'hC3, 1'b0, 1'b0, 8'h00, 1'b0);
        chk8("b2b_gap", 8'(last_t - t1), 8'd35);

        // Random words with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            frame(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
        end

        // Reset mid-frame at t+13.
        start = 1'b1;
        din = 8'($urandom);
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk_reset_vals();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk1("no_done_after_reset", o_done, 1'b0);
            chk1("idle_after_reset", o_busy, 1'b0);
        end
        frame(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);

        // Minimum bit period on the DIV=2 instance.
        sel = 1'b1;
        tick();
        frame(8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        frame(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
        sel = 1'b0;
        tick();

        // last_tick stuck low.
        force_lt0 = 1'b1;
        w = 8'($urandom);
`ifdef SERIAL_TX_SEQ_CHECK_EN
        frame(w, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk1("err_sticky", o_err, 1'b1);
        end
`else
        start = 1'b1;
        din = w;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 3 * 32; c++) begin
            tick();
            chk1("stuck_err", o_err, 1'b0);
            chk1("stuck_done", o_done, 1'b0);
            chk1("stuck_busy", o_busy, 1'b1);
        end
`endif
        reset = 1'b1;
        #1;
        chk_reset_vals();
        force_lt0 = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        frame(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_tx_sequencer.md
# serial_tx_sequencer

Control stage that sits directly upstream of the start/done parallel-to-serial shift register. It accepts a parallel word over a valid/ready handshake and drives the shift register's `Trigger`, `ctrl` and `d` inputs: one LOAD, then one SHIFT_L per bit period. It monitors the register's `last_tick` to end the frame and reports completion with a one-cycle `done` pulse. Bits leave the shift register MSB-first on its `q` output; each bit is held for exactly `DIV` clock cycles.

## Interface
- `N`, default 8: word width; must equal the downstream shift register's `N`.
- `DIV`, default 16: clock cycles per bit period; minimum 2.
- `clk` in, 1: clock.
- `reset` in, 1: asynchronous, active-high.
- `start` in, 1: request to send `din`.
- `din` in, N: word to send; sampled only on acceptance.
- `ready` out, 1: high in IDLE; acceptance is `start & ready`.
- `busy` out, 1: high from the cycle after acceptance until `done` inclusive.
- `done` out, 1: one-cycle pulse when the frame completes.
- `err` out, 1: sticky frame-length error; see Configuration.
- `sr_trigger` out, 1: drives shift register `Trigger`.
- `sr_ctrl` out, 2: drives shift register `ctrl`.
- `sr_d` out, N: drives shift register `d`; this is the held word.
- `sr_last_tick` in, 1: from shift register `last_tick`.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE
  - `ready`=1, `sr_trigger`=0, `sr_ctrl`=NOP.
  - On `start`: capture `din` into the hold register, then go to LOAD.
- LOAD (1 cycle)
  - `sr_trigger`=1, `sr_ctrl`=LOAD.
  - Clear the bit-period counter, then go to SHIFT.
- SHIFT
  - The bit-period counter runs 0..DIV-1 and wraps.
  - In the cycle the counter is at DIV-1:
    - if `sr_last_tick`=0: `sr_trigger`=1, `sr_ctrl`=SHIFT_L, stay in SHIFT;
    - if `sr_last_tick`=1: no trigger, go to DONE.
  - All other cycles: `sr_trigger`=0, `sr_ctrl`=NOP.
- DONE (1 cycle)
  - `done`=1, `ready`=0, then go to IDLE.
- `sr_trigger` is never high outside the LOAD and SHIFT cases above. The downstream counter advances on every trigger, including NOP, so this rule is required.
- `start` while not `ready` is ignored. There is no queuing.
- `sr_d` holds the captured word from acceptance until the next acceptance.

## Timing
- Reset values:
  - state IDLE;
  - `ready`=1;
  - `busy`, `done`, `err`, `sr_trigger` = 0;
  - `sr_ctrl`=NOP (2'b00);
  - `sr_d`=0;
  - bit-period counter 0.
- Reset mid-frame aborts immediately: no `done`, and outputs return to reset values. The downstream register is reset by the same `reset`.
- Acceptance at cycle t:
  - LOAD at t+1;
  - bit k (k=0 is the MSB) is on `q` during cycles t+2+k·DIV .. t+1+(k+1)·DIV;
  - `done` at t+2+N·DIV;
  - `ready` returns at t+3+N·DIV.
- Back-to-back: a `start` in the first cycle `ready` returns is accepted. Frame period is N·DIV+3 cycles.
- `sr_ctrl` encoding: NOP=00, SHIFT_L=01, SHIFT_R=10, LOAD=11. SHIFT_R is never issued.

## Configuration
- Macro `SERIAL_TX_SEQ_CHECK_EN`.
- Defined:
  - An internal shift counter (width clog2(N)) counts issued SHIFT_L triggers.
  - If the counter reaches N-1 at a period end and `sr_last_tick`=0, or `sr_last_tick`=1 earlier than that: set `err` (sticky until reset) and go to DONE without triggering.
- Undefined:
  - `err` is tied to 0.
  - The frame ends solely on `sr_last_tick`.

## Structure
- Shared package holds:
  - the ctrl encodings NOP/SHIFT_L/SHIFT_R/LOAD, which are also used by the shift register;
  - the state encoding IDLE/LOAD/SHIFT/DONE.
- One sub-module: `bit_period_counter`. It is a modulo-DIV counter with a synchronous clear and a terminal-count output; its width is clog2(DIV).

## Test plan
- Basic frame: N=8, DIV=4, paired with the shift register, `start` with `din`=8'hA5 at t.
  - `q` = 1,0,1,0,0,1,0,1, each bit 4 cycles, starting at t+2.
  - `done` only at t+34.
  - Exactly one LOAD and seven SHIFT_L triggers.
- Busy rejection: `start` with 8'hFF during a frame.
  - Ignored; the in-flight word is unchanged; `sr_d` stays 8'hA5.
- Back-to-back: 8'h3C then 8'hC3 with `start` held high.
  - Second acceptance at t+35.
  - Second frame bits 1,1,0,0,0,0,1,1.
- Reset mid-frame: assert `reset` at t+13.
  - All outputs at reset values the same cycle.
  - No `done`; next `start` gives a normal frame.
- Minimum DIV: DIV=2, N=8, word 8'h01.
  - `done` at t+18.
  - `q`=1 only during t+16..t+17.
- Checker (macro defined): force `sr_last_tick`=0.
  - `err` rises at t+2+N·DIV-1 and `done` pulses the next cycle.
  - `err` stays high until `reset`.
  - With the macro undefined, the same stimulus keeps SHIFT running and `err` stays 0.
